// File: rtl/game_speed_scheduler.sv
// Run/pause/game-over sequencer with a periodic game tick whose period
// shortens by a fixed step every TICKS_PER_LEVEL ticks, floored at MIN_PERIOD.
module game_speed_scheduler #(
    parameter int CNT_W           = 28,
    parameter int START_PERIOD    = 200000,
    parameter int MIN_PERIOD      = 100000,
    parameter int PERIOD_STEP     = 20000,
    parameter int TICKS_PER_LEVEL = 10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_btn,
    input  logic             pause_btn,
    input  logic             collide,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic [2:0]       level,
    output logic [1:0]       state,
    output logic             game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] START_P  = CNT_W'(START_PERIOD);
    localparam logic [CNT_W:0]   MIN_P_W  = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W:0]   STEP_W   = (CNT_W+1)'(PERIOD_STEP);
    localparam logic [14:0]      TPL_LAST = 15'(TICKS_PER_LEVEL - 1);

    state_t           cur_state, nxt_state;
    logic             start_q, pause_q;
    logic             start_rise, pause_rise;
    logic             counting, reinit;
    logic [CNT_W-1:0] counter, counter_d;
    logic [14:0]      tick_cnt, tick_cnt_d;
    logic [CNT_W-1:0] period_d;
    logic [2:0]       level_d;
    logic             tick_d;
    logic [CNT_W:0]   period_dec;

    assign start_rise = start_btn & ~start_q;
    assign pause_rise = pause_btn & ~pause_q;
    assign period_dec = {1'b0, period} - STEP_W;
    assign state      = cur_state;

    // The resume edge performs the count step the pausing edge skipped,
    // so the total RUN time between ticks stays exactly 'period'.
    assign counting = ((cur_state == S_RUN) && !collide && !pause_rise) ||
                      ((cur_state == S_PAUSE) && pause_rise);
    assign reinit   = ((cur_state == S_IDLE) || (cur_state == S_OVER)) && start_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
            game_over <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            game_over <= (nxt_state == S_OVER);
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:  if (start_rise) nxt_state = S_RUN;
            S_RUN: begin
                if (collide)         nxt_state = S_OVER;
                else if (pause_rise) nxt_state = S_PAUSE;
            end
            S_PAUSE: if (pause_rise) nxt_state = S_RUN;
            S_OVER:  if (start_rise) nxt_state = S_RUN;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        counter_d  = counter;
        tick_cnt_d = tick_cnt;
        period_d   = period;
        level_d    = level;
        tick_d     = 1'b0;
        if (cur_state == S_IDLE) counter_d = '0;
        if (reinit) begin
            counter_d  = '0;
            tick_cnt_d = '0;
            period_d   = START_P;
            level_d    = '0;
        end else if (counting) begin
            if (counter == period - CNT_W'(1)) begin
                counter_d = '0;
                tick_d    = 1'b1;
                if (tick_cnt == TPL_LAST) begin
                    tick_cnt_d = '0;
                    if (!period_dec[CNT_W] && (period_dec >= MIN_P_W)) begin
                        period_d = period_dec[CNT_W-1:0];
                        level_d  = (level == 3'd7) ? level : level + 3'd1;
                    end else if (period != MIN_P) begin
                        period_d = MIN_P;
                        level_d  = (level == 3'd7) ? level : level + 3'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt + 15'd1;
                end
            end else begin
                counter_d = counter + CNT_W'(1);
            end
        end
    end

    // Button history resets high so a button held through reset makes no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b1;
            pause_q  <= 1'b1;
            counter  <= '0;
            tick_cnt <= '0;
            period   <= START_P;
            level    <= '0;
            tick     <= 1'b0;
        end else begin
            start_q  <= start_btn;
            pause_q  <= pause_btn;
            counter  <= counter_d;
            tick_cnt <= tick_cnt_d;
            period   <= period_d;
            level    <= level_d;
            tick     <= tick_d;
        end
    end

endmodule

// File: tb/tb_game_speed_scheduler.sv
// Directed bench for game_speed_scheduler using small period parameters.
module tb_game_speed_scheduler;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_btn = 1'b0;
    logic          pause_btn = 1'b0;
    logic          collide = 1'b0;
    logic          tick;
    logic [CW-1:0] period;
    logic [2:0]    level;
    logic [1:0]    state;
    logic          game_over;

    int n_cmp = 0;
    int n_bad = 0;

    game_speed_scheduler #(
        .CNT_W           (CW),
        .START_PERIOD    (20),
        .MIN_PERIOD      (10),
        .PERIOD_STEP     (4),
        .TICKS_PER_LEVEL (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .collide   (collide),
        .tick      (tick),
        .period    (period),
        .level     (level),
        .state     (state),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until tick is seen high; bounded so a dead tick shows up as a bad gap.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 200);
    endtask

    int gap_exp [15] = '{20, 20, 20, 16, 16, 16, 12, 12, 12, 10, 10, 10, 10, 10, 10};
    int per_after[6] = '{20, 16, 12, 10, 10, 10};
    int lvl_after[6] = '{0, 1, 2, 3, 3, 3};

    initial begin
        int n;
        int extra;
        int ticks;

        // reset and idle
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_tick", tick, 0);
        check("rst_period", period, 20);
        check("rst_level", level, 0);
        check("rst_over", game_over, 0);
        repeat (3) step();
        rst_n = 1'b1;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        check("idle_ticks", ticks, 0);
        check("idle_state", state, 0);
        check("idle_period", period, 20);
        check("idle_level", level, 0);
        check("idle_over", game_over, 0);

        // start and speed ramp
        start_btn = 1'b1;
        step();
        check("start_state", state, 1);
        start_btn = 1'b0;
        extra = 0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 5) start_btn = 1'b1;
            wait_tick(n);
            if (i == 5) start_btn = 1'b0;
            check($sformatf("gap%0d", i), n + extra, gap_exp[i-1]);
            check($sformatf("period%0d", i), period, per_after[i/3]);
            check($sformatf("level%0d", i), level, lvl_after[i/3]);
            extra = 0;
            if (i == 1) begin
                step();
                check("tick_width", tick, 0);
                extra = 1;
            end
        end
        check("ramp_state", state, 1);

        // collision at terminal count
        repeat (9) step();
        collide = 1'b1;
        step();
        check("over_state", state, 3);
        check("over_tick", tick, 0);
        check("over_flag", game_over, 1);
        collide = 1'b0;
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tick === 1'b1) ticks++;
        end
        check("over_ticks", ticks, 0);
        pause_btn = 1'b1;
        step();
        pause_btn = 1'b0;
        step();
        check("over_pause_ign", state, 3);
        start_btn = 1'b1;
        step();
        check("restart_state", state, 1);
        check("restart_period", period, 20);
        check("restart_level", level, 0);
        check("restart_over", game_over, 0);
        start_btn = 1'b0;
        wait_tick(n);
        check("restart_gap", n, 20);

        // pause 7 cycles after a tick, resume preserves remaining interval
        repeat (6) step();
        pause_btn = 1'b1;
        step();
        check("pause_state", state, 2);
        pause_btn = 1'b0;
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 10) collide = 1'b1;
            if (i == 11) collide = 1'b0;
            if (i == 20) start_btn = 1'b1;
            if (i == 22) start_btn = 1'b0;
            step();
            if (tick === 1'b1) ticks++;
        end
        check("pause_ticks", ticks, 0);
        check("pause_hold", state, 2);
        check("pause_over", game_over, 0);
        pause_btn = 1'b1;
        step();
        check("resume_state", state, 1);
        pause_btn = 1'b0;
        wait_tick(n);
        check("resume_gap", n, 13);
        wait_tick(n);
        check("post_resume_gap", n, 20);
        check("lvl1_period", period, 16);
        check("lvl1_level", level, 1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(n);
            check($sformatf("l1gap%0d", i), n, 16);
        end
        check("lvl2_period", period, 12);
        check("lvl2_level", level, 2);

        // async reset mid-run, start held across release
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_state", state, 0);
        check("mrst_tick", tick, 0);
        check("mrst_period", period, 20);
        check("mrst_level", level, 0);
        check("mrst_over", game_over, 0);
        start_btn = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("held_start", state, 0);
        start_btn = 1'b0;
        step();
        check("released", state, 0);
        start_btn = 1'b1;
        step();
        check("repress", state, 1);
        start_btn = 1'b0;
        wait_tick(n);
        check("repress_gap", n, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
